rotary_decoder: RTL and testbench

Front-end for the rotary-encoder/WS2812B design. It synchronizes and debounces the raw encoder pins A, B and the push switch, then decodes the quadrature sequence. It emits single-cycle `rot_up`, `rot_dn` and `push` strobes that feed the LED controller directly. It is the producer of the step/press events the controller consumes.

---
 rtl/rotary_decoder.sv | 151 +++++++++++++++
 tb/tb_rotary_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rotary_decoder.sv
// ---------------------------------------------------------------------------
// rotary_decoder
//
// Front end for the rotary encoder. Each raw pin is passed through a two-flop
// synchronizer and a per-channel debouncer. The debounced A/B pair is then
// decoded as a quadrature sequence. Every output is a registered one-cycle
// strobe.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive differing cycles needed to accept a change
//   CNT_W           - width of each debounce counter (must hold DEBOUNCE_CYCLES)
//
// Ports:
//   clk     in   system clock, all state on the rising edge
//   res_n   in   asynchronous active-low reset
//   enc_a   in   raw encoder channel A (idle high)
//   enc_b   in   raw encoder channel B (idle high)
//   enc_sw  in   raw push switch (active-low)
//   rot_up  out  one-cycle strobe, clockwise step
//   rot_dn  out  one-cycle strobe, counter-clockwise step
//   push    out  one-cycle strobe, debounced press
//
// Build option:
//   ROTARY_FULLSTEP_EN - when defined, transitions are summed and one strobe
//   is emitted per detent (on entry to 11). When undefined, every valid
//   transition strobes immediately.
// ---------------------------------------------------------------------------
module rotary_decoder #(
    parameter int DEBOUNCE_CYCLES = 40000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic res_n,
    input  logic enc_a,
    input  logic enc_b,
    input  logic enc_sw,
    output logic rot_up,
    output logic rot_dn,
    output logic push
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order in all 3-bit vectors: [2] = A, [1] = B, [0] = switch.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [1:0]       prev_q, prev_d;
    logic             sw_prev_q, sw_prev_d;
    logic             rot_up_q, rot_up_d;
    logic             rot_dn_q, rot_dn_d;
    logic             push_q, push_d;
    logic signed [1:0] dir;
`ifdef ROTARY_FULLSTEP_EN
    logic signed [3:0] acc_q, acc_d;
    logic signed [3:0] acc_sum;
`endif

    // +1 for a clockwise transition, -1 for counter-clockwise, 0 otherwise.
    // Two-bit changes fall through to 0, so illegal transitions are ignored.
    function automatic logic signed [1:0] step_dir(input logic [1:0] from_ab,
                                                   input logic [1:0] to_ab);
        case ({from_ab, to_ab})
            4'b1110, 4'b1000, 4'b0001, 4'b0111: step_dir = 2'sd1;
            4'b1101, 4'b0100, 4'b0010, 4'b1011: step_dir = -2'sd1;
            default:                            step_dir = 2'sd0;
        endcase
    endfunction

    always_comb begin
        sync1_d = {enc_a, enc_b, enc_sw};
        sync2_d = sync1_q;
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            // Counter only runs while the input disagrees with the accepted
            // value; any agreement restarts it from zero.
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dir       = step_dir(prev_q, stable_q[2:1]);
        prev_d    = stable_q[2:1];
        sw_prev_d = stable_q[0];
        push_d    = sw_prev_q & ~stable_q[0];
        rot_up_d  = 1'b0;
        rot_dn_d  = 1'b0;
`ifdef ROTARY_FULLSTEP_EN
        acc_sum = acc_q + {{2{dir[1]}}, dir};
        acc_d   = acc_sum;
        // Entry into the detent position decides the whole detent and
        // always restarts the sum, so partial turns leave nothing behind.
        if (stable_q[2:1] == 2'b11 && prev_q != 2'b11) begin
            rot_up_d = (acc_sum == 4'sd4);
            rot_dn_d = (acc_sum == -4'sd4);
            acc_d    = '0;
        end
`else
        rot_up_d = (dir == 2'sd1);
        rot_dn_d = (dir == -2'sd1);
`endif
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sync1_q   <= 3'b111;
            sync2_q   <= 3'b111;
            stable_q  <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            prev_q    <= 2'b11;
            sw_prev_q <= 1'b1;
            rot_up_q  <= 1'b0;
            rot_dn_q  <= 1'b0;
            push_q    <= 1'b0;
`ifdef ROTARY_FULLSTEP_EN
            acc_q     <= '0;
`endif
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            prev_q    <= prev_d;
            sw_prev_q <= sw_prev_d;
            rot_up_q  <= rot_up_d;
            rot_dn_q  <= rot_dn_d;
            push_q    <= push_d;
`ifdef ROTARY_FULLSTEP_EN
            acc_q     <= acc_d;
`endif
        end
    end

    assign rot_up = rot_up_q;
    assign rot_dn = rot_dn_q;
    assign push   = push_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// ---------------------------------------------------------------------------
// tb_rotary_decoder
//
// Directed bench for rotary_decoder with DEBOUNCE_CYCLES = 4. Expectations
// adapt to whether ROTARY_FULLSTEP_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_rotary_decoder;

    localparam int DC = 4;
    localparam int LAT = DC + 3;   // input applied -> strobe observed
`ifdef ROTARY_FULLSTEP_EN
    localparam int PER_DETENT = 1;
    localparam int FULL       = 1;
`else
    localparam int PER_DETENT = 4;
    localparam int FULL       = 0;
`endif

    logic clk = 1'b0;
    logic res_n;
    logic enc_a, enc_b, enc_sw;
    logic rot_up, rot_dn, push;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int up_hi, dn_hi, push_hi, up_rise, dn_rise, push_rise, both_hi;
    int last_up, last_dn, last_push;
    int a_chg, a_chg_cyc;
    logic up_l, dn_l, push_l, a_l;
    int applied, t0;

    rotary_decoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .clk    (clk),
        .res_n  (res_n),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .enc_sw (enc_sw),
        .rot_up (rot_up),
        .rot_dn (rot_dn),
        .push   (push)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        up_hi = 0; dn_hi = 0; push_hi = 0;
        up_rise = 0; dn_rise = 0; push_rise = 0; both_hi = 0;
        last_up = -1; last_dn = -1; last_push = -1;
        a_chg = 0; a_chg_cyc = -1;
    endtask

    // One clock, sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rot_up === 1'b1) begin
            up_hi++;
            if (up_l !== 1'b1) begin up_rise++; last_up = cyc; end
        end
        if (rot_dn === 1'b1) begin
            dn_hi++;
            if (dn_l !== 1'b1) begin dn_rise++; last_dn = cyc; end
        end
        if (push === 1'b1) begin
            push_hi++;
            if (push_l !== 1'b1) begin push_rise++; last_push = cyc; end
        end
        if (rot_up === 1'b1 && rot_dn === 1'b1) both_hi++;
        if (dut.stable_q[2] !== a_l) begin a_chg++; a_chg_cyc = cyc; end
        up_l = rot_up; dn_l = rot_dn; push_l = push; a_l = dut.stable_q[2];
    endtask

    task automatic hold(input logic [1:0] ab, input int n);
        {enc_a, enc_b} = ab;
        applied = cyc;
        repeat (n) tick();
    endtask

    initial begin
        enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b1;
        res_n = 1'b1;
        up_l = 1'b0; dn_l = 1'b0; push_l = 1'b0; a_l = 1'b1;
        clear_counts();

        // Reset behaviour
        #2 res_n = 1'b0;
        #1;
        chk("rst_async_up", int'(rot_up), 0);
        chk("rst_async_dn", int'(rot_dn), 0);
        chk("rst_async_push", int'(push), 0);
        repeat (4) tick();
        chk("rst_hold_outputs", up_hi + dn_hi + push_hi, 0);
        res_n = 1'b1;
        repeat (100) tick();
        chk("post_rst_quiet", up_hi + dn_hi + push_hi, 0);
        chk("post_rst_stable_a", int'(dut.stable_q[2]), 1);

        // Clockwise detent
        clear_counts();
        hold(2'b10, 20);
        hold(2'b00, 20);
        hold(2'b01, 20);
        hold(2'b11, 20);
        chk("cw_up_pulses", up_rise, PER_DETENT);
        chk("cw_up_width", up_hi, up_rise);
        chk("cw_dn_zero", dn_hi, 0);
        chk("cw_latency", last_up - applied, LAT);

        // Counter-clockwise detent
        clear_counts();
        hold(2'b01, 20);
        hold(2'b00, 20);
        hold(2'b10, 20);
        hold(2'b11, 20);
        chk("ccw_dn_pulses", dn_rise, PER_DETENT);
        chk("ccw_dn_width", dn_hi, dn_rise);
        chk("ccw_up_zero", up_hi, 0);
        chk("ccw_latency", last_dn - applied, LAT);

        // Bounce rejection on A
        clear_counts();
        for (int i = 0; i < 16; i++) begin
            enc_a = ~enc_a;
            repeat (2) tick();
        end
        chk("bounce_no_strobe", up_hi + dn_hi + push_hi, 0);
        chk("bounce_stable_a_held", a_chg, 0);
        enc_a = 1'b0;
        t0 = cyc;
        repeat (20) tick();
        chk("bounce_one_change", a_chg, 1);
        chk("bounce_change_delay", a_chg_cyc - t0, DC + 2);
        chk("bounce_dn_after_hold", dn_rise, 1 - FULL);
        hold(2'b11, 20);
        chk("bounce_up_on_return", up_rise, 1 - FULL);

        // Illegal transitions, then a partial turn
        clear_counts();
        hold(2'b00, 20);
        hold(2'b11, 20);
        chk("illegal_no_strobe", up_hi + dn_hi, 0);
        hold(2'b10, 20);
        hold(2'b11, 20);
        chk("partial_up", up_rise, 1 - FULL);
        chk("partial_dn", dn_rise, 1 - FULL);
`ifdef ROTARY_FULLSTEP_EN
        chk("partial_acc_zero", int'(dut.acc_q), 0);
`endif

        // Push alone
        clear_counts();
        enc_sw = 1'b0;
        t0 = cyc;
        repeat (20) tick();
        enc_sw = 1'b1;
        repeat (20) tick();
        chk("push_pulses", push_rise, 1);
        chk("push_width", push_hi, 1);
        chk("push_latency", last_push - t0, LAT);
        chk("push_no_rot", up_hi + dn_hi, 0);

        // Push concurrent with a clockwise detent
        clear_counts();
        enc_sw = 1'b0;
        t0 = cyc;
        hold(2'b10, 20);
        hold(2'b00, 20);
        hold(2'b01, 20);
        enc_sw = 1'b1;
        hold(2'b11, 20);
        chk("combo_push", push_rise, 1);
        chk("combo_push_latency", last_push - t0, LAT);
        chk("combo_up", up_rise, PER_DETENT);
        chk("combo_dn", dn_hi, 0);

        // Reset in the middle of a detent
        clear_counts();
        hold(2'b10, 20);
        hold(2'b00, 10);
        chk("midrst_pre_up", up_rise, 2 * (1 - FULL));
        res_n = 1'b0;
        #1;
        chk("midrst_async_outputs", int'(rot_up) + int'(rot_dn) + int'(push), 0);
`ifdef ROTARY_FULLSTEP_EN
        chk("midrst_acc_cleared", int'(dut.acc_q), 0);
`endif
        repeat (3) tick();
        res_n = 1'b1;
        clear_counts();
        a_l = dut.stable_q[2];
        hold(2'b00, 20);
        hold(2'b11, 20);
        chk("midrst_no_strobe", up_hi + dn_hi + push_hi, 0);

        chk("never_up_and_dn", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
